hazard_unit: RTL and testbench

Hazard detection and forwarding control for the 5-stage pipeline, evaluated against the instruction in ID. Drives the `stall` input of the ID/EX register, which loads a bubble, and holds the PC and IF/ID. Generates the one-hot ALU operand selects that ID/EX carries into execute. Also enforces the program-memory structural gap and counts stall cycles for performance monitoring.

---
 rtl/hazard_unit_pkg.sv | 11 +
 rtl/hazard_unit_if.sv | 39 +++
 rtl/hazard_unit_operand_fwd_sel.sv | 22 ++
 rtl/hazard_unit.sv | 79 +++++++
 tb/tb_hazard_unit.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared operand-select encodings, gap FSM states and default widths
package hazard_unit_pkg;
    localparam int REG_ADDR_W_DEF = 5;
    typedef logic [4:0] sel_t;
    localparam sel_t SEL_REG   = 5'b00001;
    localparam sel_t SEL_EXMEM = 5'b00010;
    localparam sel_t SEL_MEMWB = 5'b00100;
    localparam sel_t SEL_IMM   = 5'b01000;
    localparam sel_t SEL_ZERO  = 5'b10000;
    typedef enum logic {ST_RUN = 1'b0, ST_PM_BUSY = 1'b1} state_t;
endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline-side signals seen by the hazard unit and the controls it returns
interface hazard_unit_if
    import hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int PERF_W     = 16
) ();
    logic [REG_ADDR_W-1:0] id_top_addr;
    logic                  id_top_used;
    logic                  id_top_imm;
    logic [REG_ADDR_W-1:0] id_bot_addr;
    logic                  id_bot_used;
    logic                  id_bot_imm;
    logic                  id_prog_mem;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic [1:0]            ex_reg_file_wen;
    logic                  ex_is_load;
    logic [REG_ADDR_W-1:0] mem_rd_addr;
    logic [1:0]            mem_reg_file_wen;
    logic                  flush;
    logic                  stall;
    logic                  pc_hold;
    logic                  if_id_hold;
    sel_t                  alu_top_select;
    sel_t                  alu_bot_select;
    logic [PERF_W-1:0]     stall_count;
    modport master (
        output id_top_addr, id_top_used, id_top_imm, id_bot_addr, id_bot_used, id_bot_imm,
        output id_prog_mem, ex_rd_addr, ex_reg_file_wen, ex_is_load, mem_rd_addr,
        output mem_reg_file_wen, flush,
        input  stall, pc_hold, if_id_hold, alu_top_select, alu_bot_select, stall_count
    );
    modport slave (
        input  id_top_addr, id_top_used, id_top_imm, id_bot_addr, id_bot_used, id_bot_imm,
        input  id_prog_mem, ex_rd_addr, ex_reg_file_wen, ex_is_load, mem_rd_addr,
        input  mem_reg_file_wen, flush,
        output stall, pc_hold, if_id_hold, alu_top_select, alu_bot_select, stall_count
    );
endinterface

// File: rtl/hazard_unit_operand_fwd_sel.sv
// operand_fwd_sel: one-hot ALU operand source for one ID operand, youngest producer wins
module operand_fwd_sel
    import hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] i_addr,
    input  logic                  i_used,
    input  logic                  i_imm,
    input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
    input  logic                  i_ex_wr,
    input  logic [REG_ADDR_W-1:0] i_mem_rd_addr,
    input  logic                  i_mem_wr,
    output sel_t                  o_sel
);
    always_comb begin
        o_sel = i_imm                               ? SEL_IMM   :
                !i_used                             ? SEL_ZERO  :
                (i_ex_wr && i_addr == i_ex_rd_addr)   ? SEL_EXMEM :
                (i_mem_wr && i_addr == i_mem_rd_addr) ? SEL_MEMWB : SEL_REG;
    end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use and program-memory gap stalls, operand forwarding selects,
// and a saturating stall-cycle counter for the 5-stage pipeline.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int PM_GAP     = 2,
    parameter int PERF_W     = 16
) (
    input logic          clock,
    input logic          nreset,
    hazard_unit_if.slave bus
);
    localparam int GAP_W = PM_GAP > 0 ? $clog2(PM_GAP + 1) : 1;

    state_t             r_state, w_state_nxt;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_nxt;
    logic [PERF_W-1:0]  r_stall_count;
    logic               w_ex_wr, w_mem_wr, w_load_use, w_pm_hazard, w_hazard, w_issue, w_stall;
    sel_t               w_top_sel, w_bot_sel;

    assign w_ex_wr  = |bus.ex_reg_file_wen;
    assign w_mem_wr = |bus.mem_reg_file_wen;

    operand_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_top (
        .i_addr(bus.id_top_addr), .i_used(bus.id_top_used), .i_imm(bus.id_top_imm),
        .i_ex_rd_addr(bus.ex_rd_addr), .i_ex_wr(w_ex_wr),
        .i_mem_rd_addr(bus.mem_rd_addr), .i_mem_wr(w_mem_wr), .o_sel(w_top_sel)
    );
    operand_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_bot (
        .i_addr(bus.id_bot_addr), .i_used(bus.id_bot_used), .i_imm(bus.id_bot_imm),
        .i_ex_rd_addr(bus.ex_rd_addr), .i_ex_wr(w_ex_wr),
        .i_mem_rd_addr(bus.mem_rd_addr), .i_mem_wr(w_mem_wr), .o_sel(w_bot_sel)
    );

    // Load data only exists after MEM, so an EX load feeding ID cannot be forwarded yet
    assign w_load_use = bus.ex_is_load & w_ex_wr &
        ((bus.id_top_used & !bus.id_top_imm & (bus.id_top_addr == bus.ex_rd_addr)) |
         (bus.id_bot_used & !bus.id_bot_imm & (bus.id_bot_addr == bus.ex_rd_addr)));
    assign w_pm_hazard = (r_state == ST_PM_BUSY) & bus.id_prog_mem;
    assign w_hazard    = (w_load_use | w_pm_hazard) & !bus.flush;
    assign w_issue     = bus.id_prog_mem & !w_hazard & !bus.flush;
    assign w_stall     = nreset & w_hazard;

    // The gap keeps counting under flush: it guards an access already in flight
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        if (r_state == ST_RUN) begin
            if (w_issue && PM_GAP > 0) begin
                w_state_nxt = ST_PM_BUSY;
                w_gap_nxt   = GAP_W'(PM_GAP);
            end
        end else begin
            w_gap_nxt   = r_gap_cnt - 1'b1;
            w_state_nxt = (r_gap_cnt == GAP_W'(1)) ? ST_RUN : ST_PM_BUSY;
        end
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_state       <= ST_RUN;
            r_gap_cnt     <= '0;
            r_stall_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_nxt;
            if (w_stall && r_stall_count != '1)
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign bus.stall          = w_stall;
    assign bus.pc_hold        = w_stall;
    assign bus.if_id_hold     = w_stall;
    assign bus.alu_top_select = nreset ? w_top_sel : SEL_REG;
    assign bus.alu_bot_select = nreset ? w_bot_sel : SEL_REG;
    assign bus.stall_count    = r_stall_count;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: table vectors, corner-case sequences and random stimulus against a
// cycle-count reference model of the hazard unit.
module tb_hazard_unit;
    localparam int AW  = 5;
    localparam int GAP = 2;
    localparam int PW  = 4;
    localparam int SAT = (1 << PW) - 1;

    logic clock  = 1'b0;
    logic nreset = 1'b0;
    always #5 clock = ~clock;

    hazard_unit_if #(.REG_ADDR_W(AW), .PERF_W(PW)) bus ();
    hazard_unit #(.REG_ADDR_W(AW), .PM_GAP(GAP), .PERF_W(PW)) dut (
        .clock(clock), .nreset(nreset), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_issue = -100;
    int m_cnt = 0;

    typedef struct {
        logic [AW-1:0] ta; logic tu; logic ti;
        logic [AW-1:0] ba; logic bu; logic bi;
        logic [AW-1:0] exa; logic [1:0] exw; logic exl;
        logic [AW-1:0] mema; logic [1:0] memw;
        logic [4:0] e_top; logic [4:0] e_bot; logic e_stall;
    } vec_t;
    vec_t vecs[8];

    function automatic logic [4:0] m_sel(logic [AW-1:0] a, logic u, logic im);
        if (im) return 5'b01000;
        if (!u) return 5'b10000;
        if (bus.ex_reg_file_wen != 0 && a == bus.ex_rd_addr) return 5'b00010;
        if (bus.mem_reg_file_wen != 0 && a == bus.mem_rd_addr) return 5'b00100;
        return 5'b00001;
    endfunction

    function automatic logic m_stall();
        logic lu;
        if (!nreset || bus.flush) return 1'b0;
        lu = bus.ex_is_load && bus.ex_reg_file_wen != 0 &&
             ((bus.id_top_used && !bus.id_top_imm && bus.id_top_addr == bus.ex_rd_addr) ||
              (bus.id_bot_used && !bus.id_bot_imm && bus.id_bot_addr == bus.ex_rd_addr));
        return lu || (bus.id_prog_mem && (cyc - last_issue) <= GAP);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp_model(string nm);
        logic s;
        s = m_stall();
        chk({nm, ".stall"}, 32'(bus.stall), 32'(s));
        chk({nm, ".pc_hold"}, 32'(bus.pc_hold), 32'(s));
        chk({nm, ".if_id_hold"}, 32'(bus.if_id_hold), 32'(s));
        chk({nm, ".top"}, 32'(bus.alu_top_select),
            32'(nreset ? m_sel(bus.id_top_addr, bus.id_top_used, bus.id_top_imm) : 5'b00001));
        chk({nm, ".bot"}, 32'(bus.alu_bot_select),
            32'(nreset ? m_sel(bus.id_bot_addr, bus.id_bot_used, bus.id_bot_imm) : 5'b00001));
        chk({nm, ".count"}, 32'(bus.stall_count), 32'(m_cnt));
    endtask

    task automatic tick();
        logic s, iss;
        s = m_stall();
        iss = nreset && bus.id_prog_mem && !s && !bus.flush;
        @(posedge clock);
        if (!nreset) begin
            last_issue = -100;
            m_cnt = 0;
        end else begin
            if (iss) last_issue = cyc;
            if (s && m_cnt < SAT) m_cnt++;
        end
        cyc++;
        #1;
    endtask

    task automatic idle();
        bus.id_top_addr = '0; bus.id_top_used = 0; bus.id_top_imm = 0;
        bus.id_bot_addr = '0; bus.id_bot_used = 0; bus.id_bot_imm = 0;
        bus.id_prog_mem = 0; bus.ex_rd_addr = '0; bus.ex_reg_file_wen = 0;
        bus.ex_is_load = 0; bus.mem_rd_addr = '0; bus.mem_reg_file_wen = 0; bus.flush = 0;
    endtask

    task automatic do_reset();
        idle();
        nreset = 0;
        tick();
        nreset = 1;
    endtask

    task automatic load_use_inputs();
        idle();
        bus.ex_is_load = 1; bus.ex_rd_addr = 5; bus.ex_reg_file_wen = 2'b01;
        bus.id_bot_addr = 5; bus.id_bot_used = 1;
    endtask

    initial begin
        vecs[0] = '{3, 1, 0, 3, 1, 1, 3, 2'b01, 0, 3, 2'b01, 5'b00010, 5'b01000, 0};
        vecs[1] = '{3, 1, 0, 3, 1, 1, 3, 2'b00, 0, 3, 2'b01, 5'b00100, 5'b01000, 0};
        vecs[2] = '{3, 0, 0, 7, 1, 0, 3, 2'b10, 0, 9, 2'b01, 5'b10000, 5'b00001, 0};
        vecs[3] = '{0, 1, 0, 0, 1, 0, 0, 2'b11, 0, 0, 2'b01, 5'b00010, 5'b00010, 0};
        vecs[4] = '{4, 1, 0, 5, 1, 0, 5, 2'b00, 0, 4, 2'b10, 5'b00100, 5'b00001, 0};
        vecs[5] = '{6, 1, 0, 1, 0, 0, 6, 2'b01, 1, 2, 2'b00, 5'b00010, 5'b10000, 1};
        vecs[6] = '{6, 1, 1, 6, 0, 0, 6, 2'b01, 1, 2, 2'b00, 5'b01000, 5'b10000, 0};
        vecs[7] = '{6, 1, 0, 2, 0, 1, 6, 2'b00, 1, 6, 2'b01, 5'b00100, 5'b01000, 0};

        do_reset();
        chk("reset.count", 32'(bus.stall_count), 0);
        chk("reset.stall", 32'(bus.stall), 0);

        foreach (vecs[i]) begin
            idle();
            bus.id_top_addr = vecs[i].ta; bus.id_top_used = vecs[i].tu; bus.id_top_imm = vecs[i].ti;
            bus.id_bot_addr = vecs[i].ba; bus.id_bot_used = vecs[i].bu; bus.id_bot_imm = vecs[i].bi;
            bus.ex_rd_addr = vecs[i].exa; bus.ex_reg_file_wen = vecs[i].exw; bus.ex_is_load = vecs[i].exl;
            bus.mem_rd_addr = vecs[i].mema; bus.mem_reg_file_wen = vecs[i].memw;
            #1;
            chk($sformatf("vec%0d.top", i), 32'(bus.alu_top_select), 32'(vecs[i].e_top));
            chk($sformatf("vec%0d.bot", i), 32'(bus.alu_bot_select), 32'(vecs[i].e_bot));
            chk($sformatf("vec%0d.stall", i), 32'(bus.stall), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d.pc_hold", i), 32'(bus.pc_hold), 32'(vecs[i].e_stall));
            tick();
        end

        do_reset();
        load_use_inputs();
        #1;
        chk("lu.stall", 32'(bus.stall), 1);
        chk("lu.pc_hold", 32'(bus.pc_hold), 1);
        chk("lu.if_id_hold", 32'(bus.if_id_hold), 1);
        tick();
        idle();
        bus.id_bot_addr = 5; bus.id_bot_used = 1; bus.mem_rd_addr = 5; bus.mem_reg_file_wen = 2'b01;
        #1;
        chk("lu.next_bot", 32'(bus.alu_bot_select), 32'(5'b00100));
        chk("lu.next_stall", 32'(bus.stall), 0);
        chk("lu.count", 32'(bus.stall_count), 1);

        do_reset();
        bus.id_prog_mem = 1;
        #1;
        chk("pm.c0_stall", 32'(bus.stall), 0);
        tick();
        chk("pm.c1_stall", 32'(bus.stall), 1);
        tick();
        chk("pm.c2_stall", 32'(bus.stall), 1);
        tick();
        chk("pm.c3_stall", 32'(bus.stall), 0);
        chk("pm.count", 32'(bus.stall_count), 2);
        tick();
        idle();
        tick();
        tick();

        do_reset();
        load_use_inputs();
        bus.flush = 1;
        #1;
        chk("fl.lu_stall", 32'(bus.stall), 0);
        idle();
        bus.id_prog_mem = 1;
        tick();
        bus.flush = 1;
        #1;
        chk("fl.busy_stall", 32'(bus.stall), 0);
        tick();
        bus.flush = 0;
        #1;
        chk("fl.c2_stall", 32'(bus.stall), 1);
        tick();
        chk("fl.c3_stall", 32'(bus.stall), 0);
        idle();
        tick();
        tick();
        tick();

        do_reset();
        bus.id_prog_mem = 1;
        tick();
        bus.id_top_addr = 3; bus.id_top_used = 1; bus.ex_rd_addr = 3; bus.ex_reg_file_wen = 2'b01;
        nreset = 0;
        #1;
        chk("rst.top", 32'(bus.alu_top_select), 32'(5'b00001));
        chk("rst.bot", 32'(bus.alu_bot_select), 32'(5'b00001));
        chk("rst.stall", 32'(bus.stall), 0);
        tick();
        nreset = 1;
        #1;
        chk("rst.after_stall", 32'(bus.stall), 0);
        chk("rst.after_count", 32'(bus.stall_count), 0);
        chk("rst.after_top", 32'(bus.alu_top_select), 32'(5'b00010));
        idle();
        tick();
        tick();
        tick();

        do_reset();
        load_use_inputs();
        for (int i = 0; i < 20; i++) tick();
        chk("sat.count", 32'(bus.stall_count), SAT);
        chk("sat.stall", 32'(bus.stall), 1);

        do_reset();
        for (int i = 0; i < 2000; i++) begin
            bus.id_top_addr = AW'($urandom_range(0, 3)); bus.id_top_used = 1'($urandom);
            bus.id_top_imm = ($urandom_range(0, 3) == 0);
            bus.id_bot_addr = AW'($urandom_range(0, 3)); bus.id_bot_used = 1'($urandom);
            bus.id_bot_imm = ($urandom_range(0, 3) == 0);
            bus.id_prog_mem = ($urandom_range(0, 2) == 0);
            bus.ex_rd_addr = AW'($urandom_range(0, 3)); bus.ex_reg_file_wen = 2'($urandom);
            bus.ex_is_load = 1'($urandom);
            bus.mem_rd_addr = AW'($urandom_range(0, 3)); bus.mem_reg_file_wen = 2'($urandom);
            bus.flush = ($urandom_range(0, 7) == 0);
            nreset = ($urandom_range(0, 49) != 0);
            #1;
            cmp_model("rnd");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
